// File: rtl/seven_seg_scan_ctrl_pkg.sv
// rtl/seven_seg_scan_ctrl_pkg.sv - shared types and constants for the seven-segment scan controller
package seven_seg_scan_ctrl_pkg;

    localparam int CODE_W_DEF = 3;

    // Wide enough for the largest supported display; callers slice to NUM_DIGITS.
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_timer.sv
// rtl/seven_seg_scan_timer.sv - per-digit slot counter with blank/show terminal-count flags
module seven_seg_scan_timer #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic blank_end,
    output logic slot_end
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);

    logic [CNT_W-1:0] cnt;

    assign blank_end = (cnt == CNT_W'(BLANK_CYCLES - 1));
    assign slot_end  = (cnt == CNT_W'(SLOT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed common-anode scan controller with frame-aligned updates
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CODE_W       = CODE_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [NUM_DIGITS*CODE_W-1:0] wr_data,
    output logic [CODE_W-1:0]            seg_code,
    output logic [NUM_DIGITS-1:0]        an_n,
    output logic                         frame_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DATA_W = NUM_DIGITS * CODE_W;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ALL_OFF[NUM_DIGITS-1:0];

    scan_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [DATA_W-1:0] active;
    logic [DATA_W-1:0] active_nxt;
    logic [DATA_W-1:0] pend_data;
    logic              pending;
    logic              run;
    logic              blank_end;
    logic              slot_end;
    logic              last_digit;
    logic              boundary;
    logic              commit;
    logic              xfer;

    function automatic logic [CODE_W-1:0] digit_code(input logic [DATA_W-1:0] d,
                                                      input logic [IDX_W-1:0]  i);
        return d[i*CODE_W +: CODE_W];
    endfunction

    seven_seg_scan_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    assign pending    = !wr_ready;
    assign run        = enable && (state != ST_IDLE);
    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign idx_nxt    = last_digit ? '0 : idx + IDX_W'(1);
    assign boundary   = run && (state == ST_SHOW) && slot_end && last_digit;
    assign commit     = (state == ST_IDLE) || boundary;
    assign xfer       = wr_valid && !pending;

    // A beat landing on a commit cycle skips the pending stage entirely.
    always_comb begin
        active_nxt = active;
        if (commit) begin
            if (xfer) begin
                active_nxt = wr_data;
            end else if (pending) begin
                active_nxt = pend_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= '0;
            pend_data <= '0;
            wr_ready  <= 1'b1;
        end else begin
            active <= active_nxt;
            if (commit) begin
                wr_ready <= 1'b1;
            end else if (xfer) begin
                pend_data <= wr_data;
                wr_ready  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            an_n       <= AN_OFF;
            seg_code   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    an_n <= AN_OFF;
                    idx  <= '0;
                    if (enable) begin
                        state    <= ST_BLANK;
                        seg_code <= digit_code(active_nxt, '0);
                    end
                end
                ST_BLANK: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        an_n  <= AN_OFF;
                    end else if (blank_end) begin
                        state <= ST_SHOW;
                        an_n  <= ~(NUM_DIGITS'(1) << idx);
                    end
                end
                ST_SHOW: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        an_n  <= AN_OFF;
                    end else if (slot_end) begin
                        state      <= ST_BLANK;
                        an_n       <= AN_OFF;
                        idx        <= idx_nxt;
                        seg_code   <= digit_code(active_nxt, idx_nxt);
                        frame_done <= last_digit;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                    an_n  <= AN_OFF;
                end
            endcase
        end
    end

endmodule
